cmd_frame_parser: RTL and testbench

Parametrised command-frame engine between the RS232 byte receiver/transmitter and the token-dispenser/LED handlers. Collects one verb byte plus `NUM_ARGS` argument bytes and answers ping internally. Other verbs go to a downstream handler over a valid/done handshake, and the parser returns a two-byte response (verb echo, status). An optional inter-byte timeout discards stalled frames.

---
 rtl/cmd_pkg.sv | 26 ++
 rtl/cmd_tx_seq.sv | 42 ++++
 rtl/cmd_frame_parser.sv | 214 +++++++++++++++++++++
 tb/tb_cmd_frame_parser.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared constants for the command-frame parser: FSM state encoding, verb and status codes.
package cmd_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned CODE_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ANNOUNCE  = 4'd0,
        WAIT_TX   = 4'd1,
        WAIT_VERB = 4'd2,
        WAIT_ARG  = 4'd3,
        DECODE    = 4'd4,
        DISPATCH  = 4'd5,
        RESP_VERB = 4'd6,
        RESP_STAT = 4'd7
    } state_t;

    localparam logic [CODE_W-1:0] VERB_NULL    = 8'h00;
    localparam logic [CODE_W-1:0] VERB_PING    = 8'h02;
    localparam logic [CODE_W-1:0] VERB_TIMEOUT = 8'hEE;

    localparam logic [CODE_W-1:0] ST_OK        = 8'h00;
    localparam logic [CODE_W-1:0] ST_BAD_VERB  = 8'hE1;
    localparam logic [CODE_W-1:0] ST_TIMEOUT   = 8'hE2;

endpackage

// File: rtl/cmd_tx_seq.sv
// Transmit sequencer: registers the tx_start pulse and held tx_data, remembers where the FSM
// resumes after the byte, and masks tx_busy for the first WAIT_TX cycle.
module cmd_tx_seq
    import cmd_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk50m,
    input  logic              reset,
    input  logic              send,
    input  logic [DATA_W-1:0] send_data,
    input  state_t            send_ret,
    input  logic              waiting,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output state_t            ret_state,
    output logic              release_c
);

    // guard is high during the first WAIT_TX cycle, before the transmitter reports busy
    logic guard;

    always_ff @(posedge clk50m) begin
        if (reset) begin
            tx_start  <= 1'b0;
            tx_data   <= '0;
            ret_state <= WAIT_VERB;
            guard     <= 1'b0;
        end else begin
            tx_start <= send;
            guard    <= send;
            if (send) begin
                tx_data   <= send_data;
                ret_state <= send_ret;
            end
        end
    end

    assign release_c = waiting && !guard && !tx_busy;

endmodule

// File: rtl/cmd_frame_parser.sv
// Command-frame parser: collects verb + NUM_ARGS bytes, answers ping locally, dispatches other
// verbs to a handler and returns verb echo + status. Optional inter-byte timeout: CMD_TIMEOUT_EN.
module cmd_frame_parser
    import cmd_pkg::*;
#(
    parameter int unsigned       NUM_ARGS       = 3,
    parameter int unsigned       DATA_W         = 8,
    parameter int unsigned       TIMEOUT_CYCLES = 500000,
    parameter logic [DATA_W-1:0] ANNOUNCE_BYTE  = DATA_W'(8'hA5)
) (
    input  logic                       clk50m,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_valid,
    input  logic                       tx_busy,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       cmd_valid,
    output logic [DATA_W-1:0]          cmd_verb,
    output logic [NUM_ARGS*DATA_W-1:0] cmd_args,
    input  logic                       cmd_done,
    input  logic [DATA_W-1:0]          cmd_status,
    output logic [3:0]                 state_out
);

    localparam int unsigned IDX_W = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;

    state_t                     state;
    state_t                     next_state;
    state_t                     ret_state;
    logic                       release_c;

    logic [DATA_W-1:0]          verb_q;
    logic [NUM_ARGS*DATA_W-1:0] args_q;
    logic [IDX_W-1:0]           idx;
    logic [DATA_W-1:0]          status_q;

    logic                       send_c;
    logic [DATA_W-1:0]          send_data_c;
    state_t                     send_ret_c;
    logic                       latch_verb_c;
    logic                       store_arg_c;
    logic                       load_status_c;
    logic [DATA_W-1:0]          status_nxt_c;
    logic                       timeout_hit_c;
    logic                       expired_c;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] to_cnt;

    // inter-byte counter: only runs while an argument is outstanding
    always_ff @(posedge clk50m) begin
        if (reset || state != WAIT_ARG || rx_valid || expired_c) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign expired_c = (state == WAIT_ARG) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign expired_c      = 1'b0;
`endif

    always_ff @(posedge clk50m) begin
        if (reset) begin
            state <= ANNOUNCE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        send_c        = 1'b0;
        send_data_c   = '0;
        send_ret_c    = WAIT_VERB;
        latch_verb_c  = 1'b0;
        store_arg_c   = 1'b0;
        load_status_c = 1'b0;
        status_nxt_c  = '0;
        timeout_hit_c = 1'b0;

        case (state)
            ANNOUNCE: begin
                send_c      = 1'b1;
                send_data_c = ANNOUNCE_BYTE;
                send_ret_c  = WAIT_VERB;
                next_state  = WAIT_TX;
            end
            WAIT_TX: begin
                if (release_c) begin
                    next_state = ret_state;
                end
            end
            WAIT_VERB: begin
                if (rx_valid) begin
                    latch_verb_c = 1'b1;
                    next_state   = WAIT_ARG;
                end
            end
            WAIT_ARG: begin
                // expiry wins over a byte arriving in the same cycle
                if (expired_c) begin
                    timeout_hit_c = 1'b1;
                    load_status_c = 1'b1;
                    status_nxt_c  = DATA_W'(ST_TIMEOUT);
                    next_state    = RESP_VERB;
                end else if (rx_valid) begin
                    store_arg_c = 1'b1;
                    if (idx == IDX_W'(NUM_ARGS - 1)) begin
                        next_state = DECODE;
                    end
                end
            end
            DECODE: begin
                if (verb_q == DATA_W'(VERB_PING)) begin
                    load_status_c = 1'b1;
                    status_nxt_c  = DATA_W'(ST_OK);
                    next_state    = RESP_VERB;
                end else if (verb_q == DATA_W'(VERB_NULL)) begin
                    load_status_c = 1'b1;
                    status_nxt_c  = DATA_W'(ST_BAD_VERB);
                    next_state    = RESP_VERB;
                end else begin
                    next_state = DISPATCH;
                end
            end
            DISPATCH: begin
                if (cmd_done) begin
                    load_status_c = 1'b1;
                    status_nxt_c  = cmd_status;
                    next_state    = RESP_VERB;
                end
            end
            RESP_VERB: begin
                if (!tx_busy) begin
                    send_c      = 1'b1;
                    send_data_c = verb_q;
                    send_ret_c  = RESP_STAT;
                    next_state  = WAIT_TX;
                end
            end
            RESP_STAT: begin
                if (!tx_busy) begin
                    send_c      = 1'b1;
                    send_data_c = status_q;
                    send_ret_c  = WAIT_VERB;
                    next_state  = WAIT_TX;
                end
            end
            default: begin
                next_state = ANNOUNCE;
            end
        endcase
    end

    // frame datapath: verb, argument bytes, index and response status
    always_ff @(posedge clk50m) begin
        if (reset) begin
            verb_q    <= '0;
            args_q    <= '0;
            idx       <= '0;
            status_q  <= '0;
            cmd_valid <= 1'b0;
        end else begin
            cmd_valid <= (next_state == DISPATCH);
            if (latch_verb_c) begin
                verb_q <= rx_data;
                idx    <= '0;
            end
            if (timeout_hit_c) begin
                verb_q <= DATA_W'(VERB_TIMEOUT);
            end
            if (store_arg_c) begin
                idx <= idx + 1'b1;
                for (int i = 0; i < NUM_ARGS; i++) begin
                    if (idx == IDX_W'(i)) begin
                        args_q[i*DATA_W +: DATA_W] <= rx_data;
                    end
                end
            end
            if (load_status_c) begin
                status_q <= status_nxt_c;
            end
        end
    end

    cmd_tx_seq #(
        .DATA_W (DATA_W)
    ) u_tx_seq (
        .clk50m    (clk50m),
        .reset     (reset),
        .send      (send_c),
        .send_data (send_data_c),
        .send_ret  (send_ret_c),
        .waiting   (state == WAIT_TX),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .ret_state (ret_state),
        .release_c (release_c)
    );

    assign cmd_verb  = verb_q;
    assign cmd_args  = args_q;
    assign state_out = state;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser with a 10-cycle transmitter busy model.
// Build with CMD_TIMEOUT_EN defined to exercise the inter-byte timeout path.
module tb_cmd_frame_parser;

    logic        clk50m     = 1'b0;
    logic        reset      = 1'b1;
    logic [7:0]  rx_data    = '0;
    logic        rx_valid   = 1'b0;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        cmd_valid;
    logic [7:0]  cmd_verb;
    logic [23:0] cmd_args;
    logic        cmd_done   = 1'b0;
    logic [7:0]  cmd_status = '0;
    logic [3:0]  state_out;

    int n_assert = 0;
    int n_fail   = 0;

    int         cyc      = 0;
    int         busy_cnt = 0;
    int         last_rx  = 0;
    int         cv_rise  = 0;
    int         cv_rises = 0;
    int         overlap  = 0;
    logic       cv_prev  = 1'b0;
    logic [7:0] tx_q[$];
    int         tx_t[$];

    cmd_frame_parser #(
        .NUM_ARGS       (3),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (100),
        .ANNOUNCE_BYTE  (8'hA5)
    ) dut (
        .clk50m     (clk50m),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .cmd_valid  (cmd_valid),
        .cmd_verb   (cmd_verb),
        .cmd_args   (cmd_args),
        .cmd_done   (cmd_done),
        .cmd_status (cmd_status),
        .state_out  (state_out)
    );

    always #10 clk50m = ~clk50m;

    assign tx_busy = (busy_cnt != 0);

    // transmitter model and event log, all stamped with the same edge counter
    always @(posedge clk50m) begin
        cyc     <= cyc + 1;
        cv_prev <= cmd_valid;
        if (rx_valid) last_rx <= cyc;
        if (cmd_valid && !cv_prev) begin
            cv_rises <= cv_rises + 1;
            cv_rise  <= cyc;
        end
        if (tx_start) begin
            tx_q.push_back(tx_data);
            tx_t.push_back(cyc);
            if (tx_busy) overlap <= overlap + 1;
        end
        if (reset)               busy_cnt <= 0;
        else if (tx_start)       busy_cnt <= 10;
        else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no end of test, expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk50m);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic send_frame(input logic [7:0] v, input logic [7:0] a0,
                              input logic [7:0] a1, input logic [7:0] a2);
        send_byte(v);
        send_byte(a0);
        send_byte(a1);
        send_byte(a2);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tx_at(input int i);
        if (i < tx_q.size()) return 32'(tx_q[i]);
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] tx_gap(input int i, input int base);
        if (i < tx_t.size()) return 32'(tx_t[i] - base);
        return 32'hDEAD;
    endfunction

    task automatic check_resp(input string tag, input int n0, input logic [7:0] b0,
                              input logic [7:0] b1);
        check({tag, "_count"}, 32'(tx_q.size()), 32'(n0 + 2));
        check({tag, "_byte0"}, tx_at(n0), 32'(b0));
        check({tag, "_byte1"}, tx_at(n0 + 1), 32'(b1));
    endtask

    initial begin
        int n0;
        int r0;

        // reset state
        tick(3);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_verb", 32'(cmd_verb), 32'd0);
        check("rst_cmd_args", 32'(cmd_args), 32'd0);
        check("rst_state", 32'(state_out), 32'd0);

        // announce: one pulse carrying A5, then nothing else
        reset = 1'b0;
        tick(1);
        check("ann_start", 32'(tx_start), 32'd1);
        check("ann_data", 32'(tx_data), 32'hA5);
        tick(1);
        check("ann_pulse_end", 32'(tx_start), 32'd0);
        tick(30);
        check("ann_count", 32'(tx_q.size()), 32'd1);
        check("ann_byte", tx_at(0), 32'hA5);
        check("ann_idle_state", 32'(state_out), 32'd2);

        // ping answered locally, echo 3 cycles after last arg, status after busy drops
        n0 = tx_q.size();
        r0 = cv_rises;
        send_frame(8'h02, 8'h11, 8'h22, 8'h33);
        tick(40);
        check_resp("ping", n0, 8'h02, 8'h00);
        check("ping_latency", tx_gap(n0, last_rx), 32'd3);
        check("ping_second_after_busy", 32'(tx_gap(n0 + 1, tx_t[n0]) > 32'd10), 32'd1);
        check("ping_no_cmd_valid", 32'(cv_rises - r0), 32'd0);

        // null verb rejected; a stray byte during the response is dropped
        n0 = tx_q.size();
        r0 = cv_rises;
        send_frame(8'h00, 8'hAA, 8'hBB, 8'hCC);
        tick(3);
        send_byte(8'h02);
        tick(40);
        check_resp("null", n0, 8'h00, 8'hE1);
        check("null_no_cmd_valid", 32'(cv_rises - r0), 32'd0);
        check("null_idle_state", 32'(state_out), 32'd2);

        // dispatched verb, handler completes 20 cycles later
        n0 = tx_q.size();
        send_frame(8'h05, 8'h01, 8'h02, 8'h03);
        tick(3);
        check("disp_rise_latency", 32'(cv_rise - last_rx), 32'd2);
        check("disp_valid", 32'(cmd_valid), 32'd1);
        check("disp_verb", 32'(cmd_verb), 32'h05);
        check("disp_args", 32'(cmd_args), 32'h030201);
        check("disp_state", 32'(state_out), 32'd5);
        check("disp_no_tx_yet", 32'(tx_q.size()), 32'(n0));
        tick(17);
        check("disp_args_held", 32'(cmd_args), 32'h030201);
        cmd_status = 8'h00;
        cmd_done   = 1'b1;
        tick(1);
        cmd_done   = 1'b0;
        check("disp_valid_drop", 32'(cmd_valid), 32'd0);
        tick(40);
        check_resp("disp", n0, 8'h05, 8'h00);

        // done in the first dispatch cycle is taken; status byte comes from the handler
        n0 = tx_q.size();
        send_frame(8'h07, 8'hAA, 8'hBB, 8'hCC);
        tick(1);
        check("fast_valid", 32'(cmd_valid), 32'd1);
        cmd_status = 8'h3C;
        cmd_done   = 1'b1;
        tick(1);
        cmd_done   = 1'b0;
        check("fast_valid_drop", 32'(cmd_valid), 32'd0);
        tick(40);
        check_resp("fast", n0, 8'h07, 8'h3C);

        // stalled frame
        n0 = tx_q.size();
        r0 = cv_rises;
        send_byte(8'h05);
        send_byte(8'h11);
        tick(200);
`ifdef CMD_TIMEOUT_EN
        check_resp("timeout", n0, 8'hEE, 8'hE2);
        check("timeout_no_cmd_valid", 32'(cv_rises - r0), 32'd0);
        check("timeout_idle_state", 32'(state_out), 32'd2);
        n0 = tx_q.size();
        send_frame(8'h02, 8'h01, 8'h02, 8'h03);
        tick(40);
        check_resp("post_timeout_ping", n0, 8'h02, 8'h00);
`else
        check("stall_no_tx", 32'(tx_q.size()), 32'(n0));
        check("stall_state", 32'(state_out), 32'd3);
        send_byte(8'h22);
        send_byte(8'h33);
        tick(2);
        check("stall_valid", 32'(cmd_valid), 32'd1);
        check("stall_args", 32'(cmd_args), 32'h332211);
        cmd_status = 8'h5A;
        cmd_done   = 1'b1;
        tick(1);
        cmd_done   = 1'b0;
        tick(40);
        check_resp("stall", n0, 8'h05, 8'h5A);
`endif

        // reset mid-dispatch: valid drops, announce resent, late done ignored
        send_frame(8'h09, 8'h01, 8'h02, 8'h03);
        tick(3);
        check("mid_valid", 32'(cmd_valid), 32'd1);
        n0    = tx_q.size();
        reset = 1'b1;
        cmd_status = 8'h77;
        cmd_done   = 1'b1;
        tick(1);
        reset    = 1'b0;
        cmd_done = 1'b0;
        check("mid_valid_drop", 32'(cmd_valid), 32'd0);
        check("mid_state", 32'(state_out), 32'd0);
        tick(5);
        cmd_done = 1'b1;
        tick(1);
        cmd_done = 1'b0;
        tick(40);
        check("mid_count", 32'(tx_q.size()), 32'(n0 + 1));
        check("mid_announce", tx_at(n0), 32'hA5);
        check("mid_idle_state", 32'(state_out), 32'd2);
        check("mid_cmd_valid", 32'(cmd_valid), 32'd0);

        check("tx_while_busy", 32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
